uart_trx: RTL and testbench

UART_TRX -- requirements
Module: uart_trx

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_trx.sv | 215 +++++++++++++++++++++
 tb/tb_uart_trx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the uart_trx transceiver.
// UART_PARITY_EN adds the PARITY state to both FSM encodings.
package uart_pkg;

  localparam int CLKS_PER_BIT_MIN = 4;
  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // Parity bit that makes the frame's one-count even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: full or half-bit load, auto-reloads on every tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic load_half,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= FULL;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (en) begin
      cnt <= (cnt == '0) ? FULL : cnt - CNT_W'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart_trx.sv
// Full-duplex UART transmitter/receiver with independent TX and RX FSMs.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
module uart_trx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data_in,
  output logic              tx_line,
  output logic              tx_active,
  output logic              done_tx,
  input  logic              rx_line,
  output logic [DATA_W-1:0] rx_data_out,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_parity_err
);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $error("uart_trx: parameter outside legal range");
  end

  localparam int BIT_CNT_W = $clog2(DATA_W_MAX);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  // ---------------- transmitter ----------------
  tx_state_t             tx_state;
  logic [DATA_W-1:0]     tx_shift;
  logic [BIT_CNT_W-1:0]  tx_bit_cnt;
  logic                  tx_stop_cnt;
  logic                  tx_tick;
`ifdef UART_PARITY_EN
  logic                  tx_par;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (tx_state != TX_IDLE),
    .load      ((tx_state == TX_IDLE) && start),
    .load_half (1'b0),
    .tick      (tx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '0;
      tx_bit_cnt  <= '0;
      tx_stop_cnt <= 1'b0;
      tx_line     <= 1'b1;
      tx_active   <= 1'b0;
      done_tx     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; only the completing
      // branch raises them, which keeps them exactly one cycle wide.
      done_tx <= 1'b0;
      case (tx_state)
        TX_IDLE: if (start) begin
          tx_shift  <= tx_data_in;
`ifdef UART_PARITY_EN
          tx_par    <= parity_bit(DATA_W_MAX'(tx_data_in), PARITY_ODD[0]);
`endif
          tx_line   <= 1'b0;
          tx_active <= 1'b1;
          tx_state  <= TX_START;
        end
        TX_START: if (tx_tick) begin
          tx_line    <= tx_shift[0];
          tx_shift   <= tx_shift >> 1;
          tx_bit_cnt <= '0;
          tx_state   <= TX_DATA;
        end
        TX_DATA: if (tx_tick) begin
          if (tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_line  <= tx_par;
            tx_state <= TX_PARITY;
`else
            tx_line     <= 1'b1;
            tx_stop_cnt <= 1'b0;
            tx_state    <= TX_STOP;
`endif
          end else begin
            tx_line    <= tx_shift[0];
            tx_shift   <= tx_shift >> 1;
            tx_bit_cnt <= tx_bit_cnt + BIT_CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (tx_tick) begin
          tx_line     <= 1'b1;
          tx_stop_cnt <= 1'b0;
          tx_state    <= TX_STOP;
        end
`endif
        TX_STOP: if (tx_tick) begin
          if (tx_stop_cnt == 1'(STOP_BITS - 1)) begin
            tx_active <= 1'b0;
            done_tx   <= 1'b1;
            tx_state  <= TX_IDLE;
          end else begin
            tx_stop_cnt <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]            rx_sync;
  logic                  rx_s;
  rx_state_t             rx_state;
  logic [DATA_W-1:0]     rx_shift;
  logic [BIT_CNT_W-1:0]  rx_bit_cnt;
  logic                  rx_tick;
`ifdef UART_PARITY_EN
  logic                  rx_par;
`endif

  // NOTE: synchronizer flops reset to the idle-high line level so release
  // from reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx_line};
  end
  assign rx_s = rx_sync[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (rx_state != RX_IDLE),
    .load      (1'b0),
    .load_half ((rx_state == RX_IDLE) && !rx_s),
    .tick      (rx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state     <= RX_IDLE;
      rx_shift     <= '0;
      rx_bit_cnt   <= '0;
      rx_data_out  <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par        <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: if (!rx_s) rx_state <= RX_START;
        // Mid-start re-check: a line already back high was only a glitch.
        RX_START: if (rx_tick) begin
          if (rx_s) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_bit_cnt <= '0;
            rx_state   <= RX_DATA;
          end
        end
        RX_DATA: if (rx_tick) begin
          rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
          if (rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else begin
            rx_bit_cnt <= rx_bit_cnt + BIT_CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (rx_tick) begin
          rx_par   <= rx_s;
          rx_state <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_tick) begin
          rx_data_out  <= rx_shift;
          rx_valid     <= 1'b1;
          rx_frame_err <= !rx_s;
`ifdef UART_PARITY_EN
          rx_parity_err <= parity_bit(DATA_W_MAX'(rx_shift), PARITY_ODD[0]) != rx_par;
`endif
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: expected TX waveform and RX words are queued
// by the stimulus and consumed by independent monitors.
module tb_uart_trx;

  localparam int CPB  = 16;
  localparam int DW   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, rx_drv, loop;
  logic [DW-1:0] tx_data_in;
  logic          tx_line, tx_active, done_tx, rx_line;
  logic [DW-1:0] rx_data_out;
  logic          rx_valid, rx_frame_err, rx_parity_err;

  assign rx_line = loop ? tx_line : rx_drv;
  always #5 clk = ~clk;

  uart_trx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data_in(tx_data_in),
    .tx_line(tx_line), .tx_active(tx_active), .done_tx(done_tx),
    .rx_line(rx_line), .rx_data_out(rx_data_out), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  typedef struct packed { logic line; logic active; logic done; } tx_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic ferr; logic perr; } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Parity bit that brings the total number of ones to even (PODD=0) or odd.
  function automatic logic ref_parity(input logic [DW-1:0] d);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return ((ones + PODD) % 2) == 1;
  endfunction

  // Expected line level for every cycle of a frame, then the done cycle.
  task automatic push_tx_frame(input logic [DW-1:0] d);
    logic    bits[$];
    tx_exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(ref_parity(d));
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      e.line = bits[i]; e.active = 1'b1; e.done = 1'b0;
      for (int c = 0; c < CPB; c++) tx_q.push_back(e);
    end
    e.line = 1'b1; e.active = 1'b0; e.done = 1'b1;
    tx_q.push_back(e);
  endtask

  // Issues start in the first cycle the model says TX is idle (or finishing).
  task automatic send_tx(input logic [DW-1:0] d);
    int      waited = 0;
    tx_exp_t idle_e;
    @(posedge clk); #1;
    while (tx_q.size() > 1 && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 5000) begin
      check("tx_idle_timeout", tx_q.size(), 1);
      return;
    end
    if (tx_q.size() == 0) begin
      idle_e.line = 1'b1; idle_e.active = 1'b0; idle_e.done = 1'b0;
      tx_q.push_back(idle_e);
    end
    start = 1'b1;
    tx_data_in = d;
    push_tx_frame(d);
    @(posedge clk); #1;
    start = 1'b0;
    tx_data_in = DW'($urandom);
  endtask

  task automatic rx_bit(input logic b);
    rx_drv = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [DW-1:0] d, input logic par, input logic stop);
    rx_exp_t e;
    e.data = d;
    e.ferr = !stop;
    e.perr = PAR_EN && (par != ref_parity(d));
    rx_q.push_back(e);
    rx_bit(1'b0);
    for (int i = 0; i < DW; i++) rx_bit(d[i]);
    if (PAR_EN) rx_bit(par);
    rx_bit(stop);
    rx_bit(1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_pending", tx_q.size(), 0);
    check("rx_pending", rx_q.size(), 0);
  endtask

  always @(negedge clk) begin : tx_monitor
    tx_exp_t e;
    if (tx_q.size() != 0) e = tx_q.pop_front();
    else begin e.line = 1'b1; e.active = 1'b0; e.done = 1'b0; end
    check("tx_line_active_done", {29'd0, tx_line, tx_active, done_tx}, {29'd0, e});
  end

  always @(negedge clk) begin : rx_monitor
    rx_exp_t e;
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        check("rx_valid_unexpected", rx_valid, 1'b0);
      end else begin
        e = rx_q.pop_front();
        check("rx_data", rx_data_out, e.data);
        check("rx_frame_err", rx_frame_err, e.ferr);
        check("rx_parity_err", rx_parity_err, e.perr);
      end
    end else if (rx_frame_err || rx_parity_err) begin
      check("rx_err_without_valid", {rx_frame_err, rx_parity_err}, 2'b00);
    end
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b0; start = 1'b0; tx_data_in = '0; rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx_line", tx_line, 1'b1);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_done_tx", done_tx, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data_out, '0);
    check("rst_rx_errs", {rx_frame_err, rx_parity_err}, 2'b00);
    rst = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Known frame, then a start pulse mid-frame that must be ignored.
    send_tx(8'hA5);
    repeat (40) @(posedge clk); #1;
    start = 1'b1; tx_data_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;

    // Back-to-back frames.
    send_tx(8'h5A);
    send_tx(DW'($urandom));
    drain();

    // Loopback.
    loop = 1'b1;
    rx_q.push_back('{data: 8'h3C, ferr: 1'b0, perr: 1'b0});
    send_tx(8'h3C);
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom);
      rx_q.push_back('{data: d, ferr: 1'b0, perr: 1'b0});
      send_tx(d);
    end
    drain();
    loop = 1'b0;

    // Glitch reject, then directed RX frames.
    rx_drv = 1'b0;
    repeat (5) @(posedge clk); #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    send_rx(8'h81, ref_parity(8'h81), 1'b1);
    send_rx(8'h55, ref_parity(8'h55), 1'b0);
    send_rx(8'h0F, 1'b1, 1'b1);

    // Random TX and RX traffic running concurrently.
    fork
      begin
        for (int i = 0; i < 8; i++) send_tx(DW'($urandom));
      end
      begin
        for (int i = 0; i < 8; i++) begin
          logic [DW-1:0] rd;
          rd = DW'($urandom);
          send_rx(rd, ref_parity(rd) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset during data bit 3 aborts the frame.
    send_tx(8'hC3);
    repeat (70) @(posedge clk); #1;
    rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    #1;
    check("midrst_tx_line", tx_line, 1'b1);
    check("midrst_tx_active", tx_active, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (250) @(posedge clk); #1;
    send_tx(8'h96);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
